cud_multi: RTL



---
 rtl/cud_pkg.sv | 23 ++
 rtl/cud_chan.sv | 117 +++++++++++
 rtl/cud_multi.sv | 60 ++++++
 3 files changed

// File: rtl/cud_pkg.sv
// Shared types for the cud_multi counter bank: mode enum, direction codes
// and the per-channel next-value result record.
package cud_pkg;

   typedef enum logic {
      CUD_WRAP = 1'b0,
      CUD_SAT  = 1'b1
   } cud_mode_e;

   localparam logic CUD_UP   = 1'b1;
   localparam logic CUD_DOWN = 1'b0;

   // Widest channel the result record can carry; cud_chan truncates to WIDTH.
   localparam int CUD_MAX_W = 32;

   typedef struct packed {
      logic [CUD_MAX_W-1:0] value;
      logic                 ovf;
      logic                 unf;
      logic                 sat;
   } cud_res_t;

endpackage

// File: rtl/cud_chan.sv
// One counter channel: next-value arithmetic, count/flag registers and a
// combinational carry_out (wrap event of this cycle) for cascading.
module cud_chan
   import cud_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             ud,
   input  logic             load_en,
   input  logic [WIDTH-1:0] load_val,
   input  logic [WIDTH-1:0] limit,
   input  logic [WIDTH-1:0] step,
   input  cud_mode_e        mode,
   output logic [WIDTH-1:0] count,
   output logic             rollover,
   output logic             underflow,
   output logic             sat_hit,
   output logic             carry_out
);

   // Two guard bits: one for the up-count carry, one for the down-count sign.
   localparam int XW = WIDTH + 2;
   localparam logic signed [XW-1:0] ONE_X = XW'(1);

   logic [WIDTH-1:0] count_q, count_d;
   logic             rollover_q, rollover_d;
   logic             underflow_q, underflow_d;
   logic             sat_hit_q, sat_hit_d;

   logic signed [XW-1:0] cnt_x, step_x, lim_x, sum_x, diff_x, wrap_x;
   cud_res_t             res;

   // NOTE: every signal written here gets a default first, so no path leaves
   // it unassigned and no latch is inferred.
   always_comb begin
      cnt_x  = $signed({2'b00, count_q});
      step_x = $signed({2'b00, step});
      lim_x  = $signed({2'b00, limit});
      sum_x  = cnt_x + step_x;
      diff_x = cnt_x - step_x;
      wrap_x = '0;
      res    = '0;
      case (ud)
         CUD_UP: begin
            if (sum_x <= lim_x) begin
               res.value = CUD_MAX_W'(sum_x[WIDTH-1:0]);
            end else if (mode == CUD_SAT) begin
               res.value = CUD_MAX_W'(limit);
               res.sat   = 1'b1;
            end else begin
               wrap_x    = sum_x - lim_x - ONE_X;
               res.value = (wrap_x > lim_x) ? CUD_MAX_W'(limit)
                                            : CUD_MAX_W'(wrap_x[WIDTH-1:0]);
               res.ovf   = 1'b1;
            end
         end
         CUD_DOWN: begin
            if (!diff_x[XW-1]) begin
               // A count left above a lowered limit is pulled back into range.
               res.value = (diff_x > lim_x) ? CUD_MAX_W'(limit)
                                            : CUD_MAX_W'(diff_x[WIDTH-1:0]);
            end else if (mode == CUD_SAT) begin
               res.sat = 1'b1;
            end else begin
               wrap_x    = diff_x + lim_x + ONE_X;
               res.value = (wrap_x[XW-1] || wrap_x > lim_x) ? CUD_MAX_W'(limit)
                                                             : CUD_MAX_W'(wrap_x[WIDTH-1:0]);
               res.unf   = 1'b1;
            end
         end
         default: res = '0;
      endcase
   end

   always_comb begin
      count_d     = count_q;
      rollover_d  = 1'b0;
      underflow_d = 1'b0;
      sat_hit_d   = 1'b0;
      carry_out   = 1'b0;
      if (load_en) begin
         count_d   = (load_val > limit) ? limit : load_val;
         sat_hit_d = (load_val > limit);
      end else if (en && step != '0) begin
         count_d     = res.value[WIDTH-1:0];
         rollover_d  = res.ovf;
         underflow_d = res.unf;
         sat_hit_d   = res.sat;
         carry_out   = res.ovf | res.unf;
      end
   end

   // NOTE: state registers use non-blocking assignment so every flop samples
   // the pre-edge values regardless of process ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q     <= '0;
         rollover_q  <= 1'b0;
         underflow_q <= 1'b0;
         sat_hit_q   <= 1'b0;
      end else begin
         count_q     <= count_d;
         rollover_q  <= rollover_d;
         underflow_q <= underflow_d;
         sat_hit_q   <= sat_hit_d;
      end
   end

   assign count     = count_q;
   assign rollover  = rollover_q;
   assign underflow = underflow_q;
   assign sat_hit   = sat_hit_q;

endmodule

// File: rtl/cud_multi.sv
// Bank of CHANNELS up/down counters with limit, wrap/saturate and load.
// Define CUD_MULTI_CASCADE_EN to chain channels into one wide counter.
module cud_multi
   import cud_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [CHANNELS-1:0]       en,
   input  logic [CHANNELS-1:0]       ud,
   input  logic [CHANNELS-1:0]       load_en,
   input  logic [CHANNELS*WIDTH-1:0] load,
   input  logic [CHANNELS*WIDTH-1:0] limit,
   input  logic [WIDTH-1:0]          step,
   input  cud_mode_e                 mode,
   output logic [CHANNELS*WIDTH-1:0] count,
   output logic [CHANNELS-1:0]       rollover,
   output logic [CHANNELS-1:0]       underflow,
   output logic [CHANNELS-1:0]       sat_hit
);

   logic [CHANNELS-1:0] en_eff;
   logic [CHANNELS-1:0] carry;
   logic                unused_carry;

   // The top channel's carry has no consumer.
   assign unused_carry = ^carry;

   for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
`ifdef CUD_MULTI_CASCADE_EN
      if (i == 0) begin : g_head
         assign en_eff[i] = en[i];
      end else begin : g_link
         assign en_eff[i] = en[i] & carry[i-1];
      end
`else
      assign en_eff[i] = en[i];
`endif

      cud_chan #(.WIDTH(WIDTH)) u_chan (
         .clk       (clk),
         .rst       (rst),
         .en        (en_eff[i]),
         .ud        (ud[i]),
         .load_en   (load_en[i]),
         .load_val  (load[i*WIDTH +: WIDTH]),
         .limit     (limit[i*WIDTH +: WIDTH]),
         .step      (step),
         .mode      (mode),
         .count     (count[i*WIDTH +: WIDTH]),
         .rollover  (rollover[i]),
         .underflow (underflow[i]),
         .sat_hit   (sat_hit[i]),
         .carry_out (carry[i])
      );
   end

endmodule
